// File: rtl/array_lut_engine.sv
// -----------------------------------------------------------------------------
// array_lut_engine
//   Command-driven lookup engine over a writable table TBL[NBANK][NROW][NCOL]
//   and a constant mirror table KTBL of the same shape. Each accepted command
//   goes through IDLE -> FETCH -> EXEC -> RESP. A result is held until it is
//   consumed.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset; reloads TBL, aborts any command
//   cmd_valid  command offered
//   cmd_ready  high only in IDLE; the command is taken when both are high
//   cmd_op     0=READ 1=WRITE 2=SLICE_WRITE 3=DIFF_ACC
//   cmd_bank   bank index      (BW bits)
//   cmd_row    row index       (RW bits)
//   cmd_col    column index    (CW bits)
//   cmd_sel    slice index     (SW bits, SLICE_WRITE only)
//   cmd_data   write / operand data
//   res_valid  result available (RESP state)
//   res_ready  result consumed when both are high
//   res_data   result value, 0 on error
//   res_err    command rejected because an index is out of range
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// FETCH  | read entry E and mirrored constant K into registers
// EXEC   | apply table write (if any), register result and error flag
// RESP   | res_valid high, result held until res_ready
// -----------------------------------------------------------------------------
module array_lut_engine #(
    parameter int NBANK = 3,
    parameter int NROW  = 2,
    parameter int NCOL  = 4,
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int BW = (NBANK  > 1) ? $clog2(NBANK)  : 1,
    localparam int RW = (NROW   > 1) ? $clog2(NROW)   : 1,
    localparam int CW = (NCOL   > 1) ? $clog2(NCOL)   : 1,
    localparam int SW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [BW-1:0]    cmd_bank,
    input  logic [RW-1:0]    cmd_row,
    input  logic [CW-1:0]    cmd_col,
    input  logic [SW-1:0]    cmd_sel,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SLICE = 2'd2;
    localparam logic [1:0] OP_DIFF  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] tbl  [NBANK][NROW][NCOL];
    logic [WIDTH-1:0] ktbl [NBANK][NROW][NCOL];

    logic [1:0]       cap_op;
    logic [BW-1:0]    cap_bank;
    logic [RW-1:0]    cap_row;
    logic [CW-1:0]    cap_col;
    logic [SW-1:0]    cap_sel;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] k_q;

    logic             cmd_err;
    logic             tbl_we;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] result;

    // Mirrored indices; on an out-of-range index these wrap, but the command
    // is then an error and K is never used.
    logic [BW-1:0] mir_bank;
    logic [RW-1:0] mir_row;
    logic [CW-1:0] mir_col;

    assign mir_bank = BW'(NBANK - 1) - cap_bank;
    assign mir_row  = RW'(NROW  - 1) - cap_row;
    assign mir_col  = CW'(NCOL  - 1) - cap_col;

    // Constant table: hard-wired to the same init pattern as TBL.
    for (genvar gb = 0; gb < NBANK; gb++) begin : g_kb
        for (genvar gr = 0; gr < NROW; gr++) begin : g_kr
            for (genvar gc = 0; gc < NCOL; gc++) begin : g_kc
                assign ktbl[gb][gr][gc] = WIDTH'(gb * NROW * NCOL + gr * NCOL + gc);
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (state == S_IDLE);
        res_valid = (state == S_RESP);
    end

    // ---------------- command capture and fetch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_op   <= OP_READ;
            cap_bank <= '0;
            cap_row  <= '0;
            cap_col  <= '0;
            cap_sel  <= '0;
            cap_data <= '0;
            e_q      <= '0;
            k_q      <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                cap_op   <= cmd_op;
                cap_bank <= cmd_bank;
                cap_row  <= cmd_row;
                cap_col  <= cmd_col;
                cap_sel  <= cmd_sel;
                cap_data <= cmd_data;
            end
            if (state == S_FETCH) begin
                e_q <= tbl[cap_bank][cap_row][cap_col];
                k_q <= ktbl[mir_bank][mir_row][mir_col];
            end
        end
    end

    // ---------------- execute datapath ----------------
    always_comb begin
        cmd_err = (32'(cap_bank) >= NBANK) ||
                  (32'(cap_row)  >= NROW)  ||
                  (32'(cap_col)  >= NCOL)  ||
                  ((cap_op == OP_SLICE) && (32'(cap_sel) >= NSLICE));

        tbl_we = !cmd_err && ((cap_op == OP_WRITE) || (cap_op == OP_SLICE));

        wr_val = cap_data;
        if (cap_op == OP_SLICE) begin
            wr_val = e_q;
            wr_val[cap_sel * SLICE +: SLICE] = cap_data[SLICE-1:0];
        end

        case (cap_op)
            OP_DIFF: result = cap_data - e_q + k_q;
            default: result = e_q;   // READ / WRITE / SLICE_WRITE return the old value
        endcase
    end

    // Table storage; reset reloads the init pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int r = 0; r < NROW; r++) begin
                    for (int c = 0; c < NCOL; c++) begin
                        tbl[b][r][c] <= WIDTH'(b * NROW * NCOL + r * NCOL + c);
                    end
                end
            end
        end else if (state == S_EXEC && tbl_we) begin
            tbl[cap_bank][cap_row][cap_col] <= wr_val;
        end
    end

    // Result registers: loaded once at EXEC, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            res_data <= cmd_err ? '0 : result;
            res_err  <= cmd_err;
        end
    end

endmodule

// File: tb/tb_array_lut_engine.sv
module tb_array_lut_engine;

    localparam int NBANK  = 3;
    localparam int NROW   = 2;
    localparam int NCOL   = 4;
    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int NENT   = NBANK * NROW * NCOL;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_bank;
    logic [0:0]  cmd_row;
    logic [1:0]  cmd_col;
    logic [1:0]  cmd_sel;
    logic [15:0] cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;

    array_lut_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];   // {err, data}
    int          lat_q[$];   // accept cycle of each expected response

    // Reference table: flat array indexed by linear entry number.
    logic [15:0] mdl [NENT];
    int          rr_mode = 0;   // 0: random res_ready, 1: hold res_ready low

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not match expectation (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) mdl[i] = 16'(i);
    endtask

    // Issue one command, predict its response from the model, queue it.
    task automatic issue(input logic [1:0] op, input int b, input int r, input int c,
                         input int sel, input logic [15:0] data, input bit expect_resp,
                         input bit use_lit, input logic [15:0] lit_d, input bit lit_e,
                         output int tries);
        bit          ok;
        bit          err;
        int          lin;
        logic [15:0] e_val, k_val, exp_d, mask;
        ok = 0;
        tries = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_bank  = 2'(b);
        cmd_row   = 1'(r);
        cmd_col   = 2'(c);
        cmd_sel   = 2'(sel);
        cmd_data  = data;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            tries++;
            @(negedge clk);
        end
        if (!ok) begin
            fail_event("accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        #1;
        if (expect_resp) begin
            err = (b >= NBANK) || (r >= NROW) || (c >= NCOL) || (op == 2'd2 && sel >= NSLICE);
            exp_d = '0;
            if (!err) begin
                lin   = b * NROW * NCOL + r * NCOL + c;
                e_val = mdl[lin];
                k_val = 16'(NENT - 1 - lin);   // mirrored entry is the reversed linear index
                case (op)
                    2'd0: exp_d = e_val;
                    2'd1: begin exp_d = e_val; mdl[lin] = data; end
                    2'd2: begin
                        exp_d = e_val;
                        mask  = 16'hF << (sel * SLICE);
                        mdl[lin] = (e_val & ~mask) | ((data & 16'hF) << (sel * SLICE));
                    end
                    default: exp_d = data - e_val + k_val;
                endcase
            end
            if (use_lit) exp_q.push_back({lit_e, lit_d});
            else         exp_q.push_back({err, exp_d});
            lat_q.push_back(cyc);
        end
        @(negedge clk);
        // scramble inputs so any uncaptured dependence shows up
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_bank  = 2'($urandom);
        cmd_row   = 1'($urandom);
        cmd_col   = 2'($urandom);
        cmd_sel   = 2'($urandom);
        cmd_data  = 16'($urandom);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_event("drain_timeout");
    endtask

    // res_ready driver
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            res_ready = (rr_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [16:0] held;
        logic [16:0] e;
        bit          holding;
        bit          prev_v;
        int          a;
        holding = 0;
        prev_v  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 0;
                prev_v  = 0;
            end else begin
                if (res_valid && !prev_v) begin
                    if (lat_q.size() == 0) fail_event("unexpected_response");
                    else begin
                        a = lat_q.pop_front();
                        check("latency", cyc - a, 2);
                    end
                end
                if (res_valid && holding) check("hold_stable", {res_err, res_data}, held);
                if (res_valid && res_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("response", {res_err, res_data}, e);
                    end
                    holding = 0;
                end else if (res_valid) begin
                    held    = {res_err, res_data};
                    holding = 1;
                end else begin
                    holding = 0;
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin
        int  t;
        bit  seen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_bank  = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        cmd_sel   = '0;
        cmd_data  = '0;
        model_reset();
        #23;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_cmd_ready", cmd_ready, 1);

        // first command right after reset release, must be taken on first edge
        issue(2'd0, 1, 0, 1, 0, 16'h0, 1, 1, 16'd9, 1'b0, t);
        check("first_accept_tries", t, 0);
        issue(2'd3, 1, 0, 1, 0, 16'd100, 1, 1, 16'd105, 1'b0, t);
        issue(2'd3, 2, 1, 3, 0, 16'd0, 1, 1, 16'd65513, 1'b0, t);
        issue(2'd2, 0, 1, 3, 1, 16'h000A, 1, 1, 16'd7, 1'b0, t);
        issue(2'd0, 0, 1, 3, 0, 16'h0, 1, 1, 16'h00A7, 1'b0, t);
        drain();

        // stalled response: data must hold and no new command may be taken
        rr_mode = 1;
        issue(2'd1, 2, 0, 0, 0, 16'hBEEF, 1, 1, 16'd16, 1'b0, t);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) fail_event("stall_valid_timeout");
        cmd_valid = 1'b1;   // offered but must not be taken while stalled
        cmd_op    = 2'd1;
        cmd_bank  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_res_valid", res_valid, 1);
        end
        cmd_valid = 1'b0;
        rr_mode = 0;
        drain();
        issue(2'd0, 2, 0, 0, 0, 16'h0, 1, 1, 16'hBEEF, 1'b0, t);

        // out-of-range bank write
        issue(2'd1, 3, 0, 0, 0, 16'h1234, 1, 1, 16'h0, 1'b1, t);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            issue(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                  1, 0, 16'h0, 1'b0, t);
        end
        drain();

        // reset during FETCH of a write: no response, no table change
        issue(2'd1, 0, 0, 0, 0, 16'h5A5A, 0, 0, 16'h0, 1'b0, t);
        rst_n = 1'b0;
        #2 check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue(2'd0, 0, 0, 0, 0, 16'h0, 1, 1, 16'h0, 1'b0, t);
        check("post_rst_accept_tries", t, 0);

        // sweep every entry against the model
        for (int b = 0; b < NBANK; b++)
            for (int r = 0; r < NROW; r++)
                for (int c = 0; c < NCOL; c++)
                    issue(2'd0, b, r, c, 0, 16'h0, 1, 0, 16'h0, 1'b0, t);
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
